uart_tx_stream: RTL

- Byte-stream serializer at the read end of the 16x8 sync FIFO.
- Takes bytes from the FIFO output over a valid/ready handshake.
- Emits them as asynchronous serial frames on a single line: start bit, data LSB first, optional parity bit, stop bit.
- Is the FIFO's downstream consumer: its data_in_ready drives the FIFO's data_out_ready.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_baud_cnt.sv | 38 +++
 rtl/uart_tx_stream.sv | 137 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and frame constants for the UART transmit path.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package uart_pkg;

  // Transmitter FSM states. PARITY is only reachable when parity is built in.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int START_BITS = 1;
  localparam int STOP_BITS  = 1;

  // Number of serial bit periods in one frame.
  function automatic int frame_bits(input int data_width, input bit parity_en);
    return START_BITS + data_width + (parity_en ? 1 : 0) + STOP_BITS;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while run is high, held at 0 otherwise.
// Latency: bit_end is combinational on the last cycle of every bit period.
// Backpressure: none; free-running whenever run is asserted.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic bit_end
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Advance while running, wrap at the end of each bit, park at 0 when stopped.
  always_comb begin
    cnt_d = '0;
    if (run && (cnt_q != CNT_LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end = run && (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_tx_stream.sv
// UART serializer fed by a valid/ready byte stream; optional parity via UART_TX_PARITY_EN.
// Latency: tx start bit from the accept edge; ready returns after (DATA_WIDTH+2[+1])*CLKS_PER_BIT cycles.
// Backpressure: data_in_ready is high only in IDLE, so exactly one byte is held per frame.
module uart_tx_stream #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  output logic                  tx,
  output logic                  busy
);
  import uart_pkg::*;

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  uart_state_e           state_q, state_d;
  logic                  tx_q, tx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  bit_end;
  logic                  accept;

`ifdef UART_TX_PARITY_EN
  logic                  parity_q, parity_d;
`else
  // Parity polarity has no meaning without the parity bit.
  logic                  unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD;
`endif

  assign data_in_ready = (state_q == IDLE);
  assign busy          = !data_in_ready;
  assign tx            = tx_q;
  assign accept        = data_in_valid && data_in_ready;

  uart_baud_cnt #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (state_q != IDLE),
    .bit_end (bit_end)
  );

  // Next-state logic; every serial bit is launched on the edge that ends the previous one.
  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    shift_d = shift_q;
    idx_d   = idx_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (accept) begin
          state_d = START;
          tx_d    = 1'b0;
          shift_d = data_in;
`ifdef UART_TX_PARITY_EN
          parity_d = (^data_in) ^ PARITY_ODD;
`endif
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = parity_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // State, line and shift registers; reset forces the line idle immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tx_q    <= 1'b1;
      shift_q <= '0;
      idx_q   <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule
